// File: rtl/conveyor_pkg.sv
// Shared types and sizing helpers for the multi-lane conveyor safety controller.
package conveyor_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_WARN    = 2'b01,
      ST_CRIT    = 2'b10,
      ST_RECOVER = 2'b11
   } lane_state_t;

   localparam int DEF_DEBOUNCE_CYC = 3;
   localparam int DEF_WARN_HOLD    = 8;
   localparam int DEF_RECOVER_CYC  = 4;

   // Width of a counter that walks 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_DEBOUNCE_W = cnt_width(DEF_DEBOUNCE_CYC);
   localparam int DEF_HOLD_W     = cnt_width(DEF_WARN_HOLD);
   localparam int DEF_RECOVER_W  = cnt_width(DEF_RECOVER_CYC);

endpackage

// File: rtl/conveyor_lane_fsm.sv
// One conveyor lane: debounce filters on warn/crit sensors, hold/recover timers and the lane FSM.
module conveyor_lane_fsm
   import conveyor_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int WARN_HOLD    = DEF_WARN_HOLD,
   parameter int RECOVER_CYC  = DEF_RECOVER_CYC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        warn_raw,
   input  logic        crit_raw,
   input  logic        ack,
   output lane_state_t state,
   output logic        crit_entry
);

   localparam int DW = cnt_width(DEBOUNCE_CYC);
   localparam int HW = cnt_width(WARN_HOLD);
   localparam int RW = cnt_width(RECOVER_CYC);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(WARN_HOLD - 1);
   localparam logic [RW-1:0] REC_LAST  = RW'(RECOVER_CYC - 1);

   logic [1:0]    raw;
   logic [1:0]    filt;
   logic [DW-1:0] db_cnt [2];
   logic          warn_f;
   logic          crit_f;

   lane_state_t   state_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [RW-1:0] rec_cnt, rec_nxt;

   assign raw    = {crit_raw, warn_raw};
   assign warn_f = filt[0];
   assign crit_f = filt[1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt <= '0;
         // NOTE: the debounce counters are a handful of flops, not a RAM, so they are reset like any other state.
         for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (raw[k] == filt[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_LAST) begin
               filt[k]   <= raw[k];
               db_cnt[k] <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + DW'(1);
            end
         end
      end
   end

   // Timers stay at zero outside their own state, which gives the reload-on-entry behaviour for free.
   always_comb begin
      // NOTE: defaults first so every path assigns each output and no latch is inferred.
      state_nxt = state;
      hold_nxt  = '0;
      rec_nxt   = '0;
      case (state)
         ST_RUN: begin
            if (crit_f)      state_nxt = ST_CRIT;
            else if (warn_f) state_nxt = ST_WARN;
         end
         ST_WARN: begin
            if (crit_f)                    state_nxt = ST_CRIT;
            else if (warn_f)               hold_nxt  = '0;
            else if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
            else                           hold_nxt  = hold_cnt + HW'(1);
         end
         ST_CRIT: begin
            if (ack && !crit_f) state_nxt = ST_RECOVER;
         end
         ST_RECOVER: begin
            if (crit_f)                    state_nxt = ST_CRIT;
            else if (rec_cnt == REC_LAST)  state_nxt = warn_f ? ST_WARN : ST_RUN;
            else                           rec_nxt   = rec_cnt + RW'(1);
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign crit_entry = (state_nxt == ST_CRIT) && (state != ST_CRIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         hold_cnt <= '0;
         rec_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         rec_cnt  <= rec_nxt;
      end
   end

endmodule

// File: rtl/conveyor_risk_ctrl.sv
// Multi-lane conveyor safety controller: per-lane FSMs, shared emergency output, saturating CRIT-entry counter.
module conveyor_risk_ctrl
   import conveyor_pkg::*;
#(
   parameter int N_LANES      = 4,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int WARN_HOLD    = DEF_WARN_HOLD,
   parameter int RECOVER_CYC  = DEF_RECOVER_CYC,
   parameter int CNT_W        = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_LANES-1:0]   warn_i,
   input  logic [N_LANES-1:0]   crit_i,
   input  logic [N_LANES-1:0]   ack_i,
   output logic [N_LANES-1:0]   sort_en_o,
   output logic [N_LANES-1:0]   warn_o,
   output logic                 emg_o,
   output logic [2*N_LANES-1:0] lane_state_o,
   output logic [CNT_W-1:0]     crit_events_o
);

   localparam int POP_W = $clog2(N_LANES + 1);
   localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
   localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

   lane_state_t        lane_state [N_LANES];
   logic [N_LANES-1:0] crit_entry;
   logic [N_LANES-1:0] in_crit;
   logic [POP_W-1:0]   entry_cnt;
   logic [SUM_W-1:0]   sum;

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      conveyor_lane_fsm #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .WARN_HOLD    (WARN_HOLD),
         .RECOVER_CYC  (RECOVER_CYC)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .warn_raw   (warn_i[i]),
         .crit_raw   (crit_i[i]),
         .ack        (ack_i[i]),
         .state      (lane_state[i]),
         .crit_entry (crit_entry[i])
      );

      assign lane_state_o[2*i +: 2] = lane_state[i];
      assign sort_en_o[i] = (lane_state[i] == ST_RUN) || (lane_state[i] == ST_WARN);
      assign warn_o[i]    = (lane_state[i] != ST_RUN);
      assign in_crit[i]   = (lane_state[i] == ST_CRIT);
   end

   assign emg_o = |in_crit;

   always_comb begin
      entry_cnt = '0;
      for (int i = 0; i < N_LANES; i++) entry_cnt = entry_cnt + POP_W'(crit_entry[i]);
   end

   assign sum = SUM_W'(crit_events_o) + SUM_W'(entry_cnt);

   always_ff @(posedge clk) begin
      if (rst)             crit_events_o <= '0;
      else if (sum > SAT)  crit_events_o <= '1;
      else                 crit_events_o <= sum[CNT_W-1:0];
   end

endmodule
